// File: rtl/ctrl_check_monitor.sv
// Checks decoder control outputs against the expected table for each retiring instruction; outputs update one cycle after the sample.
// No backpressure: one instruction is accepted per valid cycle while running, and valid is ignored once halted.
module ctrl_check_monitor #(
    parameter int DATA_WIDTH   = 32,
    parameter int CNT_WIDTH    = 16,
    parameter int TRACE_DEPTH  = 8,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid,
    input  logic                           clear,
    input  logic [DATA_WIDTH-1:0]          pc,
    input  logic [6:0]                     opcode,
    input  logic                           branch,
    input  logic                           take,
    input  logic                           mem_write,
    input  logic                           alu_src_a,
    input  logic                           alu_src_b,
    input  logic [1:0]                     result_mux,
    output logic                           done,
    output logic                           fail,
    output logic                           halted,
    output logic [DATA_WIDTH-1:0]          fail_pc,
    output logic [6:0]                     fail_opcode,
    output logic [6:0]                     fail_mask,
    output logic [CNT_WIDTH-1:0]           insn_count,
    output logic [CNT_WIDTH-1:0]           err_count,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [DATA_WIDTH-1:0]          trace_pc
);
    localparam int IW = $clog2(TRACE_DEPTH);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {RUN, DONE, FAILED} state_t;

    state_t                  state_q;
    logic                    done_q, fail_q, halted_q;
    logic [DATA_WIDTH-1:0]   fail_pc_q;
    logic [6:0]              fail_opcode_q, fail_mask_q;
    logic [CNT_WIDTH-1:0]    insn_cnt_q, insn_cnt_d, err_cnt_q, err_cnt_d;
    logic [IW-1:0]           wptr_q, rd_ptr;
    logic [DATA_WIDTH-1:0]   trace_q [TRACE_DEPTH];

    logic                    exp_b, exp_t, exp_mw, exp_a, exp_bs;
    logic [1:0]              exp_rm;
    logic                    is_branch, is_system, illegal, bt_bad;
    logic [6:0]              check_mask;

    always_comb begin
        exp_b = 1'b0; exp_t = 1'b0; exp_mw = 1'b0; exp_rm = 2'b00; exp_a = 1'b0; exp_bs = 1'b1;
        is_branch = 1'b0;
        is_system = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_LUI:    ;
            OP_AUIPC:  exp_a = 1'b1;
            OP_JAL:    begin exp_b = 1'b1; exp_t = 1'b1; exp_rm = 2'b01; exp_a = 1'b1; end
            OP_JALR:   begin exp_b = 1'b1; exp_t = 1'b1; exp_rm = 2'b01; end
            OP_BRANCH: begin is_branch = 1'b1; exp_a = 1'b1; end
            OP_LOAD:   exp_rm = 2'b10;
            OP_STORE:  exp_mw = 1'b1;
            OP_ALU:    exp_bs = 1'b0;
            OP_ALUI:   ;
            OP_SYSTEM: is_system = 1'b1;
            default:   illegal = 1'b1;
        endcase
    end

    // A conditional branch may go either way, but taking one without branch asserted is flagged on both bits.
    assign bt_bad = take & ~branch;

    always_comb begin
        check_mask = '0;
        if (illegal) begin
            check_mask = 7'b1000000;
        end else if (!is_system) begin
            check_mask = {1'b0,
                          alu_src_b ^ exp_bs,
                          alu_src_a ^ exp_a,
                          result_mux != exp_rm,
                          mem_write ^ exp_mw,
                          is_branch ? bt_bad : (take ^ exp_t),
                          is_branch ? bt_bad : (branch ^ exp_b)};
        end
    end

    assign insn_cnt_d = (&insn_cnt_q) ? insn_cnt_q : insn_cnt_q + CNT_WIDTH'(1);
    assign err_cnt_d  = (&err_cnt_q)  ? err_cnt_q  : err_cnt_q + CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q       <= RUN;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
            halted_q      <= 1'b0;
            fail_pc_q     <= '0;
            fail_opcode_q <= '0;
            fail_mask_q   <= '0;
            insn_cnt_q    <= '0;
            err_cnt_q     <= '0;
            wptr_q        <= '0;
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                trace_q[i] <= '0;
            end
        end else if (state_q == RUN && valid) begin
            insn_cnt_q      <= insn_cnt_d;
            trace_q[wptr_q] <= pc;
            wptr_q          <= wptr_q + IW'(1);
            if (is_system) begin
                state_q  <= DONE;
                done_q   <= 1'b1;
                halted_q <= 1'b1;
            end else if (check_mask != 7'b0) begin
                err_cnt_q <= err_cnt_d;
                fail_q    <= 1'b1;
                if (!fail_q) begin
                    fail_pc_q     <= pc;
                    fail_opcode_q <= opcode;
                    fail_mask_q   <= check_mask;
                end
                if (STOP_ON_FAIL) begin
                    state_q  <= FAILED;
                    halted_q <= 1'b1;
                end
            end
        end
    end

    // Pointer arithmetic wraps naturally because the depth is a power of two.
    assign rd_ptr = wptr_q - IW'(1) - trace_idx;

    assign done        = done_q;
    assign fail        = fail_q;
    assign halted      = halted_q;
    assign fail_pc     = fail_pc_q;
    assign fail_opcode = fail_opcode_q;
    assign fail_mask   = fail_mask_q;
    assign insn_count  = insn_cnt_q;
    assign err_count   = err_cnt_q;
    assign trace_pc    = trace_q[rd_ptr];

endmodule
